// File: rtl/cpu16_ctrl_pkg.sv
// Opcode, ALU/bus select and state constants shared by the control unit,
// the datapath and the testbench.
package cpu16_ctrl_pkg;

  localparam logic [5:0] OP_SUBR = 6'b000001;
  localparam logic [5:0] OP_LDAI = 6'b010010;
  localparam logic [5:0] OP_INC  = 6'b010111;
  localparam logic [5:0] OP_ADDM = 6'b100010;
  localparam logic [5:0] OP_SUBM = 6'b100011;
  localparam logic [5:0] OP_STAM = 6'b100100;
  localparam logic [5:0] OP_JMP  = 6'b110000;
  localparam logic [5:0] OP_JZ   = 6'b110001;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [2:0] BUS_NONE = 3'b000;
  localparam logic [2:0] BUS_AC   = 3'b001;
  localparam logic [2:0] BUS_MEM  = 3'b010;
  localparam logic [2:0] BUS_PC   = 3'b011;
  localparam logic [2:0] BUS_DR   = 3'b101;

  // One-hot instruction class bit positions
  localparam int CLS_SUBR = 0;
  localparam int CLS_LDAI = 1;
  localparam int CLS_INC  = 2;
  localparam int CLS_ADDM = 3;
  localparam int CLS_SUBM = 4;
  localparam int CLS_STAM = 5;
  localparam int CLS_JMP  = 6;
  localparam int CLS_JZ   = 7;
  localparam int CLS_HLT  = 8;
  localparam int CLS_W    = 9;

  typedef logic [CLS_W-1:0] cls_t;

  typedef enum logic [4:0] {
    S_F0   = 5'd0,
    S_F1   = 5'd1,
    S_F2   = 5'd2,
    S_DEC  = 5'd3,
    S_OP0  = 5'd4,
    S_OP1  = 5'd5,
    S_OP2  = 5'd6,
    S_EXL  = 5'd7,
    S_A0   = 5'd8,
    S_A1   = 5'd9,
    S_EXM  = 5'd10,
    S_W0   = 5'd11,
    S_J0   = 5'd12,
    S_SKIP = 5'd13,
    S_EXR  = 5'd14,
    S_EXI  = 5'd15,
    S_HALT = 5'd16,
    S_ILL  = 5'd17
  } state_e;

endpackage

// File: rtl/cpu16_ctrl_fsm_if.sv
// Control-unit to datapath bundle: IR/flags/memory-ready in, strobes and selects out.
interface cpu16_ctrl_fsm_if #(
  parameter int IR_W   = 16,
  parameter int REG_W  = 4,
  parameter int FLAG_W = 4
);
  logic [IR_W-1:0]   ir_value;
  logic [FLAG_W-1:0] flags_value;
  logic              mem_ready;
  logic              ir_load;
  logic              ar_load;
  logic              dr_load;
  logic              pc_load;
  logic              ac_load;
  logic              flags_load;
  logic              pc_inc;
  logic              ac_inc;
  logic              write_en;
  logic              mem_req;
  logic [3:0]        alu_sel;
  logic [2:0]        bus_sel;
  logic [REG_W-1:0]  reg_sel;
  logic              halted;
  logic              illegal_op;

  modport ctrl (
    input  ir_value, flags_value, mem_ready,
    output ir_load, ar_load, dr_load, pc_load, ac_load, flags_load,
           pc_inc, ac_inc, write_en, mem_req, alu_sel, bus_sel, reg_sel,
           halted, illegal_op
  );

  modport dp (
    output ir_value, flags_value, mem_ready,
    input  ir_load, ar_load, dr_load, pc_load, ac_load, flags_load,
           pc_inc, ac_inc, write_en, mem_req, alu_sel, bus_sel, reg_sel,
           halted, illegal_op
  );
endinterface

// File: rtl/cpu16_opcode_decoder.sv
// Maps an opcode to a one-hot instruction class; illegal when no class matches.
module cpu16_opcode_decoder
  import cpu16_ctrl_pkg::*;
#(
  parameter int OPC_W = 6
) (
  input  logic [OPC_W-1:0] opcode,
  output cls_t             cls,
  output logic             illegal
);

  always_comb begin
    cls = '0;
    case (opcode)
      OPC_W'(OP_SUBR): cls[CLS_SUBR] = 1'b1;
      OPC_W'(OP_LDAI): cls[CLS_LDAI] = 1'b1;
      OPC_W'(OP_INC):  cls[CLS_INC]  = 1'b1;
      OPC_W'(OP_ADDM): cls[CLS_ADDM] = 1'b1;
      OPC_W'(OP_SUBM): cls[CLS_SUBM] = 1'b1;
      OPC_W'(OP_STAM): cls[CLS_STAM] = 1'b1;
      OPC_W'(OP_JMP):  cls[CLS_JMP]  = 1'b1;
      OPC_W'(OP_JZ):   cls[CLS_JZ]   = 1'b1;
      OPC_W'(OP_HLT):  cls[CLS_HLT]  = 1'b1;
      default:         cls = '0;
    endcase
    illegal = (cls == '0);
  end

endmodule

// File: rtl/cpu16_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit accumulator CPU.
// F0-F2 fetch, DEC decode, OP0-OP2 operand fetch, A0/A1 operand address+read,
// EXL/EXM/EXR/EXI execute, W0 store, J0 jump, SKIP untaken JZ, HALT, ILL.
module cpu16_ctrl_fsm
  import cpu16_ctrl_pkg::*;
#(
  parameter int IR_W    = 16,
  parameter int OPC_W   = 6,
  parameter int REG_W   = 4,
  parameter int FLAG_W  = 4,
  parameter int Z_BIT   = 3,
  parameter int WAIT_EN = 1
) (
  input  logic          clk,
  input  logic          rst,
  cpu16_ctrl_fsm_if.ctrl bus
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opcode;
  cls_t             cls;
  logic             illegal;
  logic             rdy;
  logic             z_flag;
  logic             unused_ir;

  logic             ir_ld, ar_ld, dr_ld, pc_ld, ac_ld, fl_ld;
  logic             pc_inc_s, ac_inc_s, we_s, mem_req_s, halted_s, ill_s;
  logic [3:0]       alu_s;
  logic [2:0]       bus_s;
  logic [REG_W-1:0] reg_s;

  assign opcode    = bus.ir_value[IR_W-1 -: OPC_W];
  assign rdy       = (WAIT_EN != 0) ? bus.mem_ready : 1'b1;
  assign z_flag    = bus.flags_value[Z_BIT];
  assign unused_ir = ^{bus.ir_value[IR_W-OPC_W-1:REG_W], bus.flags_value};

  cpu16_opcode_decoder #(.OPC_W(OPC_W)) u_dec (
    .opcode  (opcode),
    .cls     (cls),
    .illegal (illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_F0;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_F0:  state_d = S_F1;
      S_F1:  state_d = S_F2;
      S_F2:  if (rdy) state_d = S_DEC;
      S_DEC: begin
        if (illegal)            state_d = S_ILL;
        else if (cls[CLS_SUBR]) state_d = S_EXR;
        else if (cls[CLS_INC])  state_d = S_EXI;
        else if (cls[CLS_HLT])  state_d = S_HALT;
        else if (cls[CLS_JZ])   state_d = z_flag ? S_OP0 : S_SKIP;
        else                    state_d = S_OP0;
      end
      S_OP0: state_d = S_OP1;
      S_OP1: state_d = S_OP2;
      S_OP2: begin
        if (rdy) begin
          if (cls[CLS_LDAI])                      state_d = S_EXL;
          else if (cls[CLS_JMP] || cls[CLS_JZ])   state_d = S_J0;
          else if (cls[CLS_ADDM] || cls[CLS_SUBM] || cls[CLS_STAM])
                                                  state_d = S_A0;
          else                                    state_d = S_F0;
        end
      end
      S_A0:  state_d = cls[CLS_STAM] ? S_W0 : S_A1;
      S_A1:  if (rdy) state_d = S_EXM;
      S_W0:  if (rdy) state_d = S_F0;
      S_EXL, S_EXM, S_J0, S_SKIP, S_EXR, S_EXI, S_ILL: state_d = S_F0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_F0;
    endcase
  end

  // Moore decode; only the load/write strobes of MEM states depend on rdy
  always_comb begin
    ir_ld = 1'b0; ar_ld = 1'b0; dr_ld = 1'b0; pc_ld = 1'b0;
    ac_ld = 1'b0; fl_ld = 1'b0; pc_inc_s = 1'b0; ac_inc_s = 1'b0;
    we_s = 1'b0; mem_req_s = 1'b0; halted_s = 1'b0; ill_s = 1'b0;
    alu_s = ALU_ADD; bus_s = BUS_NONE; reg_s = '0;
    case (state_q)
      S_F0, S_OP0: begin bus_s = BUS_PC; ar_ld = 1'b1; end
      S_F1, S_OP1, S_SKIP: pc_inc_s = 1'b1;
      S_F2:  begin bus_s = BUS_MEM; mem_req_s = 1'b1; ir_ld = rdy; end
      S_OP2, S_A1: begin bus_s = BUS_MEM; mem_req_s = 1'b1; dr_ld = rdy; end
      S_EXL: begin bus_s = BUS_DR; ac_ld = 1'b1; fl_ld = 1'b1; end
      S_A0:  begin bus_s = BUS_DR; ar_ld = 1'b1; end
      S_EXM: begin
        alu_s = cls[CLS_SUBM] ? ALU_SUB : ALU_ADD;
        ac_ld = 1'b1; fl_ld = 1'b1;
      end
      S_W0:  begin bus_s = BUS_AC; mem_req_s = 1'b1; we_s = rdy; end
      S_J0:  begin bus_s = BUS_DR; pc_ld = 1'b1; end
      S_EXR: begin
        reg_s = bus.ir_value[REG_W-1:0]; alu_s = ALU_SUB;
        ac_ld = 1'b1; fl_ld = 1'b1;
      end
      S_EXI:  begin ac_inc_s = 1'b1; fl_ld = 1'b1; end
      S_HALT: halted_s = 1'b1;
      S_ILL:  ill_s = 1'b1;
      default: ;
    endcase
  end

  // Reset blanks every output, including the F0 decode held during reset
  assign bus.ir_load    = rst & ir_ld;
  assign bus.ar_load    = rst & ar_ld;
  assign bus.dr_load    = rst & dr_ld;
  assign bus.pc_load    = rst & pc_ld;
  assign bus.ac_load    = rst & ac_ld;
  assign bus.flags_load = rst & fl_ld;
  assign bus.pc_inc     = rst & pc_inc_s;
  assign bus.ac_inc     = rst & ac_inc_s;
  assign bus.write_en   = rst & we_s;
  assign bus.mem_req    = rst & mem_req_s;
  assign bus.halted     = rst & halted_s;
  assign bus.illegal_op = rst & ill_s;
  assign bus.alu_sel    = rst ? alu_s : 4'b0000;
  assign bus.bus_sel    = rst ? bus_s : 3'b000;
  assign bus.reg_sel    = rst ? reg_s : '0;

endmodule

// File: tb/tb_cpu16_ctrl_fsm.sv
// Randomized bench for cpu16_ctrl_fsm: per-instruction expected strobe sequences
// built from the instruction descriptions, with random memory wait states.
module tb_cpu16_ctrl_fsm;
  import cpu16_ctrl_pkg::*;

  typedef struct packed {
    logic       ir_load, ar_load, dr_load, pc_load, ac_load, flags_load;
    logic       pc_inc, ac_inc, write_en, mem_req, halted, illegal_op;
    logic [3:0] alu_sel;
    logic [2:0] bus_sel;
    logic [3:0] reg_sel;
  } out_t;

  typedef struct packed {
    logic mem;
    out_t o;
  } step_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  step_t q[$];

  cpu16_ctrl_fsm_if #(.IR_W(16), .REG_W(4), .FLAG_W(4)) bus_if ();

  cpu16_ctrl_fsm #(
    .IR_W(16), .OPC_W(6), .REG_W(4), .FLAG_W(4), .Z_BIT(3), .WAIT_EN(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic out_t sample();
    out_t s;
    s.ir_load = bus_if.ir_load;   s.ar_load = bus_if.ar_load;
    s.dr_load = bus_if.dr_load;   s.pc_load = bus_if.pc_load;
    s.ac_load = bus_if.ac_load;   s.flags_load = bus_if.flags_load;
    s.pc_inc = bus_if.pc_inc;     s.ac_inc = bus_if.ac_inc;
    s.write_en = bus_if.write_en; s.mem_req = bus_if.mem_req;
    s.halted = bus_if.halted;     s.illegal_op = bus_if.illegal_op;
    s.alu_sel = bus_if.alu_sel;   s.bus_sel = bus_if.bus_sel;
    s.reg_sel = bus_if.reg_sel;
    return s;
  endfunction

  function automatic out_t o_bus(input logic [2:0] b);
    out_t o = '0;
    o.bus_sel = b;
    return o;
  endfunction

  function automatic bit is_legal(input logic [5:0] opc);
    return opc inside {OP_SUBR, OP_LDAI, OP_INC, OP_ADDM, OP_SUBM,
                       OP_STAM, OP_JMP, OP_JZ, OP_HLT};
  endfunction

  // Latency table, F0 entry to next F0, with no wait states
  function automatic int base_lat(input logic [5:0] opc, input logic z);
    case (opc)
      OP_SUBR, OP_INC:  return 5;
      OP_JZ:            return z ? 8 : 5;
      OP_LDAI, OP_JMP:  return 8;
      OP_STAM:          return 9;
      OP_ADDM, OP_SUBM: return 10;
      default:          return 5;
    endcase
  endfunction

  task automatic push(input logic m, input out_t o);
    step_t s;
    s.mem = m;
    s.o = o;
    q.push_back(s);
  endtask

  task automatic push_addr_pc();
    out_t o = o_bus(BUS_PC);
    o.ar_load = 1'b1;
    push(1'b0, o);
    o = '0;
    o.pc_inc = 1'b1;
    push(1'b0, o);
  endtask

  task automatic push_read_dr();
    out_t o = o_bus(BUS_MEM);
    o.mem_req = 1'b1;
    o.dr_load = 1'b1;
    push(1'b1, o);
  endtask

  task automatic build(input logic [15:0] ir, input logic z);
    out_t o;
    logic [5:0] opc = ir[15:10];
    q.delete();
    push_addr_pc();
    o = o_bus(BUS_MEM); o.mem_req = 1'b1; o.ir_load = 1'b1;
    push(1'b1, o);
    push(1'b0, '0);
    case (opc)
      OP_SUBR: begin
        o = '0; o.reg_sel = ir[3:0]; o.alu_sel = ALU_SUB;
        o.ac_load = 1'b1; o.flags_load = 1'b1; push(1'b0, o);
      end
      OP_INC: begin
        o = '0; o.ac_inc = 1'b1; o.flags_load = 1'b1; push(1'b0, o);
      end
      OP_HLT: begin
        o = '0; o.halted = 1'b1;
        for (int k = 0; k < 20; k++) push(1'b0, o);
      end
      OP_LDAI: begin
        push_addr_pc(); push_read_dr();
        o = o_bus(BUS_DR); o.ac_load = 1'b1; o.flags_load = 1'b1; push(1'b0, o);
      end
      OP_JMP, OP_JZ: begin
        if (opc == OP_JMP || z) begin
          push_addr_pc(); push_read_dr();
          o = o_bus(BUS_DR); o.pc_load = 1'b1; push(1'b0, o);
        end else begin
          o = '0; o.pc_inc = 1'b1; push(1'b0, o);
        end
      end
      OP_ADDM, OP_SUBM: begin
        push_addr_pc(); push_read_dr();
        o = o_bus(BUS_DR); o.ar_load = 1'b1; push(1'b0, o);
        push_read_dr();
        o = '0; o.alu_sel = (opc == OP_SUBM) ? ALU_SUB : ALU_ADD;
        o.ac_load = 1'b1; o.flags_load = 1'b1; push(1'b0, o);
      end
      OP_STAM: begin
        push_addr_pc(); push_read_dr();
        o = o_bus(BUS_DR); o.ar_load = 1'b1; push(1'b0, o);
        o = o_bus(BUS_AC); o.mem_req = 1'b1; o.write_en = 1'b1; push(1'b1, o);
      end
      default: begin
        o = '0; o.illegal_op = 1'b1; push(1'b0, o);
      end
    endcase
  endtask

  // Starts just after a clk edge with the DUT in F0. stall_at/n_stall force
  // wait states on one MEM step; other MEM steps get random wait states.
  task automatic run_instr(input string name, input logic [15:0] ir,
                           input logic [3:0] fdec, input int stall_at,
                           input int n_stall);
    int   cycles = 0;
    int   stalls = 0;
    out_t e;
    logic r;
    build(ir, fdec[3]);
    for (int i = 0; i < q.size(); i++) begin
      if (!q[i].mem) begin
        bus_if.flags_value = (i == 3) ? fdec : 4'($urandom);
        bus_if.mem_ready   = 1'($urandom);
        @(negedge clk);
        check($sformatf("%s s%0d", name, i), 32'(sample()), 32'(q[i].o));
        @(posedge clk); #1;
        cycles++;
      end else begin
        int low = 0;
        do begin
          if (i == stall_at) r = (low >= n_stall);
          else               r = (low >= 2) || ($urandom_range(0, 2) != 0);
          bus_if.mem_ready   = r;
          bus_if.flags_value = 4'($urandom);
          e = q[i].o;
          if (!r) begin e.ir_load = 1'b0; e.dr_load = 1'b0; e.write_en = 1'b0; end
          @(negedge clk);
          check($sformatf("%s s%0d w%0d", name, i, low), 32'(sample()), 32'(e));
          @(posedge clk); #1;
          cycles++;
          if (!r) begin low++; stalls++; end
        end while (!r);
        if (i == 2) bus_if.ir_value = ir;
      end
    end
    if (ir[15:10] != OP_HLT)
      check($sformatf("%s lat", name), cycles, base_lat(ir[15:10], fdec[3]) + stalls);
  endtask

  initial begin
    logic [5:0]  opc;
    logic [15:0] ir;
    logic [5:0]  legal [8];
    out_t        f0;
    legal[0] = OP_SUBR; legal[1] = OP_LDAI; legal[2] = OP_INC;  legal[3] = OP_ADDM;
    legal[4] = OP_SUBM; legal[5] = OP_STAM; legal[6] = OP_JMP;  legal[7] = OP_JZ;
    f0 = o_bus(BUS_PC); f0.ar_load = 1'b1;

    bus_if.ir_value = 16'hFFFF;
    bus_if.flags_value = 4'h0;
    bus_if.mem_ready = 1'b1;
    #3;
    check("reset outputs", 32'(sample()), 32'h0);
    @(posedge clk); #1;
    check("reset held", 32'(sample()), 32'h0);
    rst = 1'b1;
    #1;
    check("release F0", 32'(sample()), 32'(f0));

    run_instr("ldai",   16'h4800, 4'b0000, -1, 0);
    run_instr("addm",   16'h8800, 4'b0000,  8, 2);
    run_instr("subm",   16'h8C33, 4'b1000, -1, 0);
    run_instr("stam",   16'h9000, 4'b0000, 10, 3);
    run_instr("jz_t",   16'hC400, 4'b1000, -1, 0);
    run_instr("jz_n",   16'hC400, 4'b0000, -1, 0);
    run_instr("jz_n2",  16'hC400, 4'b0111, -1, 0);
    run_instr("jmp",    16'hC000, 4'b0000, -1, 0);
    run_instr("subr",   16'h0405, 4'b0000, -1, 0);
    run_instr("inc",    16'h5C00, 4'b0000, -1, 0);
    run_instr("ill",    16'h3C00, 4'b0000, -1, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) < 8) opc = legal[$urandom_range(0, 7)];
      else begin
        do opc = 6'($urandom); while (is_legal(opc));
      end
      ir = {opc, 10'($urandom)};
      run_instr($sformatf("rnd%0d_%b", n, opc), ir, 4'($urandom), -1, 0);
    end

    // Asynchronous reset while waiting in A1 of an ADDM
    bus_if.mem_ready = 1'b1;
    bus_if.ir_value = 16'h8800;
    for (int k = 0; k < 8; k++) begin @(posedge clk); #1; end
    bus_if.mem_ready = 1'b0;
    #2;
    check("a1 mem_req", 32'(bus_if.mem_req), 32'd1);
    check("a1 dr_load", 32'(bus_if.dr_load), 32'd0);
    rst = 1'b0;
    #1;
    check("async rst", 32'(sample()), 32'h0);
    @(posedge clk); #1;
    check("rst hold", 32'(sample()), 32'h0);
    rst = 1'b1;
    #1;
    check("rst release F0", 32'(sample()), 32'(f0));
    run_instr("post_rst", 16'h0409, 4'b0000, -1, 0);

    run_instr("hlt", 16'hFC00, 4'b1000, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu16_ctrl_fsm.md
Name: cpu16_ctrl_fsm

Overview:
Parametrised multi-cycle control unit for the 16-bit accumulator CPU, decoding the IR and sequencing bus, register, ALU and memory control strobes.
It supports direct-addressed memory operands, a store instruction, unconditional and zero-conditional jumps, and halt.
A mem_req/mem_ready handshake lets it run against wait-state memory.
It sits between the IR/FLAGS registers and the datapath (bus mux, AR, PC, DR, AC, register file, ALU).

Parameters:
IR_W, 16, instruction register width; opcode = ir_value[IR_W-1 -: OPC_W]
OPC_W, 6, opcode width
REG_W, 4, register-select width; source register = ir_value[REG_W-1:0]
FLAG_W, 4, flags width
Z_BIT, 3, index of the zero flag in flags_value
WAIT_EN, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
ir_value  in  IR_W  current instruction register
flags_value  in  FLAG_W  current flags
mem_ready  in  1  memory access complete this cycle
ir_load, ar_load, dr_load, pc_load, ac_load, flags_load  out  1 each  register load strobes
pc_inc, ac_inc  out  1 each  increment strobes
write_en  out  1  memory write
mem_req  out  1  memory access in progress
alu_sel  out  4  ADD=0000, SUB=0001
bus_sel  out  3  000 none, 001 AC, 010 MEM, 011 PC, 101 DR
reg_sel  out  REG_W  ALU source register
halted  out  1  CPU halted
illegal_op  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset: rst=0 asynchronously forces state F0 and all outputs to 0, including the F0 decode. Outputs are Moore-decoded from state, except the load/write strobes in MEM states, which are qualified by mem_ready.
- MEM read state: mem_req=1, bus_sel=010. The target load strobe is asserted only in the cycle mem_ready=1; the FSM holds the state until that cycle. MEM write state behaves the same way with write_en=1 and bus_sel=001.
- Opcodes: SUBR 000001, LDAI 010010, INC 010111, ADDM 100010, SUBM 100011, STAM 100100, JMP 110000, JZ 110001, HLT 111111.
- Fetch sequence:
  - F0: bus_sel=011, ar_load
  - F1: pc_inc
  - F2: MEM read, ir_load
  - DEC: no strobes; branch on opcode
- Operand fetch, shared by LDAI/ADDM/SUBM/STAM/JMP/taken JZ:
  - OP0: bus_sel=011, ar_load
  - OP1: pc_inc
  - OP2: MEM read, dr_load
- Per-opcode sequences after DEC or OP2:
  - LDAI: EXL: bus_sel=101, ac_load, flags_load -> F0
  - ADDM/SUBM: A0: bus_sel=101, ar_load; A1: MEM read, dr_load; EXM: alu_sel ADD/SUB, ac_load, flags_load -> F0
  - STAM: A0; W0: MEM write (bus_sel=001, write_en) -> F0
  - JMP: J0: bus_sel=101, pc_load -> F0
  - JZ at DEC: if flags_value[Z_BIT]=1, go to OP0 and end at J0; else go to SKIP (pc_inc, skips the operand word) -> F0
  - SUBR: EXR: reg_sel=ir_value[REG_W-1:0], alu_sel=SUB, ac_load, flags_load -> F0
  - INC: EXI: ac_inc, flags_load -> F0
  - HLT: HALT state; halted=1, all other strobes 0; leaves only via reset
  - undefined opcode: ILL state, illegal_op=1 for one cycle -> F0
- Latency with mem_ready=1, from F0 entry to the next F0:
  - SUBR/INC: 5 cycles
  - JZ not taken: 5 cycles
  - LDAI/JMP/JZ taken: 8 cycles
  - STAM: 9 cycles
  - ADDM/SUBM: 10 cycles
  - each extra mem_ready=0 cycle in a MEM state adds 1 cycle
- flags_value is sampled only in DEC; a flags change in any other state has no effect.
- Unused state encodings -> F0 with all outputs 0.
- pc_load and pc_inc are never asserted together.

Decomposition:
- Package cpu16_ctrl_pkg holds the opcode, ALU-select, bus-select and state-encoding constants shared with the datapath and testbench.
- One combinational sub-module, cpu16_opcode_decoder, maps the opcode to a one-hot instruction class plus an illegal flag.

Test Plan:
1. rst=0 asserted mid-ADDM (state A1) -> outputs go to 0 in the same cycle, without waiting for a clk edge; after release, the first cycle shows bus_sel=011, ar_load=1.
2. LDAI (ir=0x4800), mem_ready=1 -> dr_load in cycle 7, then ac_load+flags_load with bus_sel=101 in cycle 8; F0 is re-entered at cycle 9.
3. ADDM with mem_ready low for 2 cycles in A1 -> mem_req=1 and dr_load=0 for those 2 cycles, dr_load on the ready cycle; alu_sel=0000 with ac_load follows; total 12 cycles.
4. JZ with flags=4'b1000 -> J0 asserts pc_load with bus_sel=101; with flags=4'b0000 -> SKIP asserts pc_inc once, no dr_load, 5 cycles.
5. SUBR with ir=0x0405 -> EXR shows reg_sel=0101, alu_sel=0001, ac_load=1, flags_load=1.
6. Opcode 001111 -> illegal_op pulses exactly 1 cycle, then F0. HLT (ir=0xFC00) -> halted=1 held for 20 cycles with no strobes.
